// File: rtl/bp_be_dcache_pkg.sv
// Shared types and helpers for the D$ replay queue.
//   replay_ptr_width(els) : bits in a queue pointer (index plus wrap bit)
//   bp_be_replay_ptr_s    : {wrap, idx} view of a queue pointer
package bp_be_dcache_pkg;

  localparam int unsigned replay_idx_max_width_lp = 16;

  // Index bits plus one wrap bit, so full and empty differ only in the wrap bit
  function automatic int unsigned replay_ptr_width(input int unsigned els);
    return $clog2(els) + 1;
  endfunction

  typedef struct packed {
    logic                               wrap;
    logic [replay_idx_max_width_lp-1:0] idx;
  } bp_be_replay_ptr_s;

endpackage

// File: rtl/bp_be_replay_ptr.sv
// Wrapping queue pointer with increment and load (load has priority).
//   clk_i, reset_i : clock, synchronous active-high reset (pointer -> 0)
//   inc_i          : advance by one
//   load_i         : replace with load_val_i
//   ptr_o          : current pointer value {wrap, idx}
module bp_be_replay_ptr #(
  parameter int unsigned width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               inc_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic [width_p-1:0] ptr_o
);

  logic [width_p-1:0] ptr_q, ptr_d;

  // Power-of-two depth means plain binary overflow gives the wrap bit for free
  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bsg_mem_1r1w.sv
// Register file with one synchronous write port and one asynchronous read port.
//   w_clk_i/w_reset_i : write clock, write-blocking reset
//   w_v_i/w_addr_i/w_data_i : write request
//   r_v_i/r_addr_i/r_data_o : combinational read (zero when r_v_i is low)
module bsg_mem_1r1w #(
  parameter int unsigned width_p                 = 8,
  parameter int unsigned els_p                   = 8,
  parameter int unsigned read_write_same_addr_p  = 0,
  parameter int unsigned addr_width_lp           = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     w_clk_i,
  input  logic                     w_reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  // Storage is not cleared on reset; writes are simply blocked while it is held
  always_ff @(posedge w_clk_i) begin
    if (w_v_i && !w_reset_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = r_v_i ? mem_q[r_addr_i] : '0;

endmodule

// File: rtl/bp_be_dcache_replay_queue.sv
// Replay queue in front of bp_be_dcache: buffers requests until commit and
// replays from the oldest uncommitted entry on rollback. Also produces the
// pipeline-matched poison strobe and the one-cycle-late payload.
// Optional feature macro: BP_BE_REPLAY_WATCHDOG_EN (consecutive-rollback lock).
//   clk_i, reset_i   : clock, synchronous active-high reset
//   v_i, data_i      : enqueue request, {late, early} payload
//   ready_o          : queue not full
//   v_o, data_o      : issuable entry and its early payload
//   yumi_i           : cache accepted data_o
//   late_data_o      : late payload of the last issued entry
//   commit_i, roll_i : cache completion / miss rollback
//   poison_o         : kill the op issued pipe_depth_p cycles ago
//   count_o          : enqueued, not committed
//   inflight_o       : issued, not committed
//   lock_o           : rollback watchdog tripped (sticky)
module bp_be_dcache_replay_queue
  import bp_be_dcache_pkg::*;
#(
  parameter int unsigned early_width_p    = 1,
  parameter int unsigned late_width_p     = 1,
  parameter int unsigned els_p            = 8,
  parameter int unsigned pipe_depth_p     = 2,
  parameter int unsigned lock_max_limit_p = 8
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 v_i,
  input  logic [late_width_p+early_width_p-1:0] data_i,
  output logic                                 ready_o,
  output logic                                 v_o,
  output logic [early_width_p-1:0]             data_o,
  input  logic                                 yumi_i,
  output logic [late_width_p-1:0]              late_data_o,
  input  logic                                 commit_i,
  input  logic                                 roll_i,
  output logic                                 poison_o,
  output logic [$clog2(els_p+1)-1:0]           count_o,
  output logic [$clog2(els_p+1)-1:0]           inflight_o,
  output logic                                 lock_o
);

  localparam int unsigned ptr_w_lp  = replay_ptr_width(els_p);
  localparam int unsigned idx_w_lp  = ptr_w_lp - 1;
  localparam int unsigned cnt_w_lp  = $clog2(els_p + 1);
  localparam int unsigned data_w_lp = late_width_p + early_width_p;

  logic [ptr_w_lp-1:0]  wptr, iptr, cptr, cptr_post;
  logic                 enq, issue;
  logic [data_w_lp-1:0] rdata;

  assign enq   = v_i & ready_o;
  // A rollback in the same cycle discards the yumi
  assign issue = yumi_i & ~roll_i;

  // Full when indices match but wrap bits differ
  assign ready_o = ~((wptr[idx_w_lp-1:0] == cptr[idx_w_lp-1:0])
                   & (wptr[ptr_w_lp-1] != cptr[ptr_w_lp-1]));
  assign v_o     = (iptr != wptr);

  // Rollback targets the commit pointer after this cycle's commit
  assign cptr_post = cptr + ptr_w_lp'(commit_i);

  bp_be_replay_ptr #(.width_p(ptr_w_lp)) wptr_u (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .inc_i     (enq),
    .load_i    (1'b0),
    .load_val_i('0),
    .ptr_o     (wptr)
  );

  bp_be_replay_ptr #(.width_p(ptr_w_lp)) iptr_u (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .inc_i     (yumi_i),
    .load_i    (roll_i),
    .load_val_i(cptr_post),
    .ptr_o     (iptr)
  );

  bp_be_replay_ptr #(.width_p(ptr_w_lp)) cptr_u (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .inc_i     (commit_i),
    .load_i    (1'b0),
    .load_val_i('0),
    .ptr_o     (cptr)
  );

  bsg_mem_1r1w #(
    .width_p(data_w_lp),
    .els_p  (els_p)
  ) mem_u (
    .w_clk_i  (clk_i),
    .w_reset_i(reset_i),
    .w_v_i    (enq),
    .w_addr_i (wptr[idx_w_lp-1:0]),
    .w_data_i (data_i),
    .r_v_i    (1'b1),
    .r_addr_i (iptr[idx_w_lp-1:0]),
    .r_data_o (rdata)
  );

  assign data_o = rdata[early_width_p-1:0];

  // Late payload captured at issue, held until the next issue
  logic [late_width_p-1:0] late_q, late_d;

  always_comb begin
    late_d = late_q;
    if (issue) begin
      late_d = rdata[data_w_lp-1:early_width_p];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      late_q <= '0;
    end else begin
      late_q <= late_d;
    end
  end

  assign late_data_o = late_q;

  // Issue history aligned to the cache pipeline depth
  logic [pipe_depth_p-1:0] issue_sr_q, issue_sr_d;

  if (pipe_depth_p == 1) begin : g_sr1
    assign issue_sr_d = issue;
  end else begin : g_srn
    assign issue_sr_d = {issue_sr_q[pipe_depth_p-2:0], issue};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      issue_sr_q <= '0;
    end else begin
      issue_sr_q <= issue_sr_d;
    end
  end

  assign poison_o = issue_sr_q[pipe_depth_p-1] & ~commit_i;

  assign count_o    = cnt_w_lp'(wptr - cptr);
  assign inflight_o = cnt_w_lp'(iptr - cptr);

`ifdef BP_BE_REPLAY_WATCHDOG_EN
  localparam int unsigned lock_w_lp = $clog2(lock_max_limit_p + 1);

  logic [lock_w_lp-1:0] roll_cnt_q, roll_cnt_d;
  logic                 lock_q, lock_d;

  // A commit clears the run; a roll in the same cycle starts a new run at one
  always_comb begin
    roll_cnt_d = roll_cnt_q;
    if (commit_i) begin
      roll_cnt_d = '0;
    end
    if (roll_i && (roll_cnt_d != lock_w_lp'(lock_max_limit_p))) begin
      roll_cnt_d = roll_cnt_d + lock_w_lp'(1);
    end
    lock_d = lock_q | (roll_cnt_d == lock_w_lp'(lock_max_limit_p));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      roll_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      roll_cnt_q <= roll_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign lock_o = lock_q;
`else
  assign lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_be_dcache_replay_queue.sv
// Directed bench for bp_be_dcache_replay_queue (els 8, depth 2, 8-bit payloads).
module tb_bp_be_dcache_replay_queue;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic [15:0] data_i;
  logic        ready_o;
  logic        v_o;
  logic [7:0]  data_o;
  logic        yumi_i;
  logic [7:0]  late_data_o;
  logic        commit_i;
  logic        roll_i;
  logic        poison_o;
  logic [3:0]  count_o;
  logic [3:0]  inflight_o;
  logic        lock_o;

  int passed = 0;
  int total  = 0;

  bp_be_dcache_replay_queue #(
    .early_width_p   (8),
    .late_width_p    (8),
    .els_p           (8),
    .pipe_depth_p    (2),
    .lock_max_limit_p(8)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i),
    .late_data_o(late_data_o),
    .commit_i   (commit_i),
    .roll_i     (roll_i),
    .poison_o   (poison_o),
    .count_o    (count_o),
    .inflight_o (inflight_o),
    .lock_o     (lock_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    v_i = 1'b0; data_i = '0; yumi_i = 1'b0; commit_i = 1'b0; roll_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic enq(input logic [15:0] d);
    v_i = 1'b1; data_i = d;
    tick();
    v_i = 1'b0; data_i = '0;
  endtask

  task automatic yumi();
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
  endtask

  initial begin
    idle();
    reset_i = 1'b1;
    tick();
    do_reset();

    // Reset state
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst_v", 32'(v_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_inflight", 32'(inflight_o), 0);
    chk("rst_poison", 32'(poison_o), 0);
    chk("rst_lock", 32'(lock_o), 0);
    chk("rst_late", 32'(late_data_o), 0);

    // Fill to full
    for (int i = 0; i < 8; i++) enq(16'(16'h1000 * i + 16'hA0 + i));
    chk("full_ready", 32'(ready_o), 0);
    chk("full_count", 32'(count_o), 8);
    chk("full_v", 32'(v_o), 1);
    chk("full_data", 32'(data_o), 32'hA0);
    enq(16'hFFFF);
    chk("full_refuse_count", 32'(count_o), 8);

    // Drain: issue all, then commit all
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 32'(data_o), 32'(8'hA0 + 8'(i)));
      yumi();
    end
    chk("drain_inflight", 32'(inflight_o), 8);
    chk("drain_v", 32'(v_o), 0);
    commit_i = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    commit_i = 1'b0;
    chk("drain_count", 32'(count_o), 0);
    chk("drain_inflight0", 32'(inflight_o), 0);
    chk("drain_ready", 32'(ready_o), 1);
    chk("drain_v0", 32'(v_o), 0);

    // Full queue: commit with enqueue refused in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) enq(16'(i));
    yumi();
    v_i = 1'b1; data_i = 16'hBEEF; commit_i = 1'b1;
    tick();
    idle();
    chk("fullcommit_count", 32'(count_o), 7);
    chk("fullcommit_ready", 32'(ready_o), 1);

    // Rollback to oldest uncommitted
    do_reset();
    enq(16'h000A); enq(16'h000B); enq(16'h000C);
    chk("roll_preA", 32'(data_o), 32'h0A);
    yumi();
    chk("roll_preB", 32'(data_o), 32'h0B);
    yumi();
    roll_i = 1'b1;
    tick();
    roll_i = 1'b0;
    chk("roll_data", 32'(data_o), 32'h0A);
    chk("roll_inflight", 32'(inflight_o), 0);
    chk("roll_count", 32'(count_o), 3);
    chk("roll_v", 32'(v_o), 1);

    // Poison two cycles after issue, masked by commit
    do_reset();
    enq(16'h0011);
    yumi();
    chk("poison_n1", 32'(poison_o), 0);
    tick();
    chk("poison_n2", 32'(poison_o), 1);
    commit_i = 1'b1;
    #1;
    chk("poison_commit", 32'(poison_o), 0);
    tick();
    commit_i = 1'b0;
    chk("poison_after", 32'(poison_o), 0);
    chk("poison_count", 32'(count_o), 0);

    // Late payload capture and hold
    do_reset();
    enq(16'h3F12);
    enq(16'h5566);
    chk("late_pre", 32'(late_data_o), 0);
    chk("late_early", 32'(data_o), 32'h12);
    yumi();
    chk("late_n1", 32'(late_data_o), 32'h3F);
    tick();
    chk("late_hold", 32'(late_data_o), 32'h3F);
    yumi_i = 1'b1; roll_i = 1'b1;
    tick();
    idle();
    chk("late_rollyumi", 32'(late_data_o), 32'h3F);
    chk("late_rollyumi_data", 32'(data_o), 32'h12);

    // Commit, roll and yumi together with A and B issued
    do_reset();
    enq(16'h010A); enq(16'h020B); enq(16'h030C);
    yumi(); yumi();
    commit_i = 1'b1; roll_i = 1'b1; yumi_i = 1'b1;
    tick();
    idle();
    chk("sim_data", 32'(data_o), 32'h0B);
    chk("sim_inflight", 32'(inflight_o), 0);
    chk("sim_count", 32'(count_o), 2);
    chk("sim_late", 32'(late_data_o), 32'h02);

    // Reset with an op in flight produces no poison
    do_reset();
    enq(16'h0001);
    yumi();
    do_reset();
    chk("rstmid_poison", 32'(poison_o), 0);
    tick();
    chk("rstmid_poison2", 32'(poison_o), 0);
    chk("rstmid_v", 32'(v_o), 0);
    chk("rstmid_count", 32'(count_o), 0);

    // Watchdog after eight consecutive rolls
    do_reset();
    enq(16'h0001);
    roll_i = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    roll_i = 1'b0;
    chk("wd_seven", 32'(lock_o), 0);
    roll_i = 1'b1;
    tick();
    roll_i = 1'b0;
`ifdef BP_BE_REPLAY_WATCHDOG_EN
    chk("wd_lock", 32'(lock_o), 1);
    tick();
    chk("wd_sticky", 32'(lock_o), 1);
`else
    chk("wd_off", 32'(lock_o), 0);
`endif
    do_reset();
    chk("wd_reset", 32'(lock_o), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bp_be_dcache_replay_queue.md
# bp_be_dcache_replay_queue

Parametrised replay queue between the issue side of a memory pipeline and `bp_be_dcache`. Requests are buffered until they complete and replayed from the oldest uncommitted entry whenever the cache reports a miss. The block also generates the pipeline-depth-matched poison strobe and the one-cycle-late payload (ptag, uncached) that the cache consumes in its TL stage. Used by the D$ testbench wrappers and by the BE memory pipe in place of a hand-built FIFO, flop and poison chain.

## Interface
Parameters:
- `early_width_p`, 1, payload bits presented to the cache in the issue cycle (dcache packet)
- `late_width_p`, 1, payload bits presented one cycle after issue (ptag, uncached)
- `els_p`, 8, queue depth; power of two, ≥2
- `pipe_depth_p`, 2, cycles from issue (`yumi_i`) to the cache's completion strobe; ≥1
- `lock_max_limit_p`, 8, consecutive-rollback limit for the watchdog

Ports:
- `clk_i`  in  1  clock
- `reset_i`  in  1  reset, synchronous, active-high
- `v_i`  in  1  enqueue valid
- `data_i`  in  late_width_p+early_width_p  `{late, early}` payload
- `ready_o`  out  1  queue not full
- `v_o`  out  1  uncommitted-and-unissued entry available
- `data_o`  out  early_width_p  early payload at issue pointer
- `yumi_i`  in  1  cache accepted `data_o`
- `late_data_o`  out  late_width_p  late payload of the last issued entry
- `commit_i`  in  1  cache completed oldest issued op (dcache `v_o`)
- `roll_i`  in  1  rollback (dcache miss)
- `poison_o`  out  1  kill op issued `pipe_depth_p` cycles ago
- `count_o`  out  clog2(els_p+1)  occupied entries (enqueued, not committed)
- `inflight_o`  out  clog2(els_p+1)  issued, not committed
- `lock_o`  out  1  watchdog tripped

## Operation
- Storage: `els_p`-entry 1r1w register file. Three pointers, each clog2(els_p)+1 bits with wrap bit: `wptr` (enqueue), `iptr` (issue), `cptr` (commit).
- Enqueue: `v_i & ready_o` writes at `wptr`, increments. `ready_o = ~(wptr.idx==cptr.idx & wptr.wrap!=cptr.wrap)`. `v_i` while not ready is ignored.
- Issue: `v_o = (iptr != wptr)`. `yumi_i` is legal only when `v_o`; it increments `iptr`.
- Commit: `commit_i` increments `cptr`; legal only when `inflight_o>0`.
- Rollback: `roll_i` sets `iptr` to the post-commit `cptr` value. The next `v_o` presents the oldest uncommitted entry.
- Simultaneous events in one cycle:
  - `roll_i` with `yumi_i`: roll wins and the yumi is discarded.
  - `commit_i` with `roll_i`: commit applies first, then the roll.
  - Enqueue with commit while full: `ready_o` is still 0, so the enqueue is refused.
- Poison: shift register `issue_sr[pipe_depth_p]` shifts in `yumi_i & ~roll_i`. `poison_o = issue_sr[last] & ~commit_i`.
- Late payload: on `yumi_i & ~roll_i`, register the late bits of the issued entry into `late_data_o`; otherwise hold.
- Occupancy: `count_o = wptr-cptr`, `inflight_o = iptr-cptr`. Both use modulo 2·els_p pointer arithmetic; the wrap bit disambiguates full from empty.

## Timing
- Reset values: all pointers 0; `ready_o=1`, `v_o=0`, `poison_o=0`, `lock_o=0`, `count_o=0`, `inflight_o=0`; `late_data_o=0`; `issue_sr=0`.
- `data_o` is combinational from `iptr`. An entry enqueued in cycle N is visible on `v_o` in N+1; there is no write-through bypass.
- `late_data_o` is valid in cycle N+1 for a yumi in cycle N.
- `poison_o` for an issue in cycle N is evaluated in cycle N+pipe_depth_p.
- `roll_i` in cycle N: `v_o` and `data_o` reflect the rolled pointer in N+1.
- Reset asserted mid-operation: all contents are discarded; no `poison_o` is emitted for ops still in flight.

## Configuration
- `BP_BE_REPLAY_WATCHDOG_EN` defined:
  - A counter of consecutive `roll_i` pulses increments on each roll and clears on `commit_i`.
  - `lock_o` asserts when the counter reaches `lock_max_limit_p`. It is sticky until reset.
  - The counter saturates at the limit.
- Undefined: no counter is built and `lock_o` is tied 0.

## Structure
- Shared package `bp_be_dcache_pkg`:
  - Pointer-width helper localparam function.
  - `bp_be_replay_ptr_s` struct `{wrap, idx}`.
- One sub-module, `bp_be_replay_ptr`: a wrapping pointer counter with increment and load. Instantiated three times.
- Storage uses `bsg_mem_1r1w`.

## Test plan
- Fill/drain (els_p=8): enqueue 8 entries with no yumi → `ready_o=0`, `count_o=8`. Yumi and commit 8 → `count_o=0`, `v_o=0`, `ready_o=1`.
- Rollback: enqueue A,B,C; yumi A,B; roll in cycle 3 → next `data_o`=A, `inflight_o=0`, `count_o=3`.
- Poison (pipe_depth_p=2): yumi in cycle 5 with no commit in cycle 7 → `poison_o=1` in cycle 7. With commit in cycle 7 → `poison_o=0`.
- Simultaneous: `commit_i`, `roll_i` and `yumi_i` in one cycle with A,B issued → `cptr`=1, next `data_o`=B, the yumi is ignored.
- Late data: enqueue `{late=0x3F, early=0x12}`, yumi in cycle N → `late_data_o=0x3F` in N+1, held until the next yumi.
- Watchdog (macro on, limit 8): 8 rolls with no commit → `lock_o=1` in the cycle after the 8th roll. With the macro off → `lock_o` remains 0.
